i2c_slave_regs: RTL and testbench
=================================

Name: i2c_slave_regs

Overview:
- I2C target (responder) answering the existing i2c master on the shared SCL/SDA bus.
- Exposes a byte-wide register file of 2^AW entries behind a 7-bit address (default 7'h3c).
- Protocol: write = [addr+W][pointer][data...]; read = [addr+R][data...] from the current pointer; pointer auto-increments.
- Oversamples SCL/SDA on the system clock. Gives the host a write-event stream and a combinational read port.

Parameters:
- SLAVE_ADDR, 7'h3c, 7-bit bus address matched against the first byte after START.
- AW, 4, register pointer width; register file depth is 2^AW bytes.

Ports:
- clk  in  1  system clock; must be ≥ 16x SCL frequency.
- rst  in  1  synchronous, active-high reset.
- scl_i  in  1  SCL line level (input only; no clock stretching).
- sda_i  in  1  SDA line level.
- sda_oe  out  1  1 = drive SDA low (open-drain); 0 = release.
- reg_wr_valid  out  1  one-clk pulse per register byte written over I2C.
- reg_wr_addr  out  AW  register index of that write.
- reg_wr_data  out  8  byte written.
- host_addr  in  AW  host-side read index.
- host_rdata  out  8  regfile[host_addr], combinational.
- busy  out  1  high from an address-matched START until STOP or NACK.

Behaviour:
- Reset: sda_oe=0, reg_wr_valid=0, reg_wr_addr=0, reg_wr_data=0, busy=0, pointer=0, all registers 0, state IDLE. Reset mid-transfer aborts immediately and SDA is released that cycle.
- Input sync: 2-FF synchronizers on scl_i and sda_i, plus one history flop each. Edges are detected on the synced values.
  - SCL rise = sample point; SCL fall = drive point.
- START = synced SDA 1->0 while synced SCL=1. STOP = SDA 0->1 while SCL=1. Both are detected in any state, including mid-byte.
  - START (incl. repeated): go to ADDR, bit count=0, release SDA.
  - STOP: go to IDLE, release SDA, busy=0.
- Bytes are MSB first. An 8-bit shift register is loaded on SCL rises, with a 3-bit counter.
- States:
  - IDLE: wait for START.
  - ADDR: after 8 bits, if addr[7:1]==SLAVE_ADDR go to ADDR_ACK and set busy; otherwise go to IGNORE with SDA released.
  - ADDR_ACK: sda_oe=1 from the SCL fall after bit 8 until the next SCL fall.
    - R/W=0: go to PTR.
    - R/W=1: go to RDATA. The first data bit is driven on that same fall.
  - PTR: 8 bits received; pointer <= byte[AW-1:0] (upper bits ignored); go to PTR_ACK (ACK as above), then WDATA.
  - WDATA: 8 bits received, then go to WDATA_ACK.
    - On the SCL fall entering WDATA_ACK: regfile[pointer] <= byte; reg_wr_valid=1 for exactly that clk, with reg_wr_addr=pointer and reg_wr_data=byte.
    - Pointer increments on the next clk.
    - ACK is driven, then return to WDATA. Unlimited bytes.
  - RDATA: on each SCL fall drive sda_oe = ~bit (bit = regfile[pointer], MSB first).
    - The byte is latched at the first-bit drive, so a concurrent I2C write cannot change it mid-byte.
    - After bit 8 the fall releases SDA; go to RDATA_ACK.
  - RDATA_ACK: sample SDA on SCL rise.
    - 0 (ACK): pointer+1; go to RDATA.
    - 1 (NACK): go to IGNORE with busy=0, SDA released.
  - IGNORE: SDA released; wait for START/STOP.
- Pointer wraps 2^AW-1 -> 0 on both write and read.
- Pointer persists across transactions; it is cleared only by rst.
- If START/STOP coincides with an SCL edge in the same clk, START/STOP takes priority; no write pulse fires for a partial byte.
- Write-pulse latency: 1 clk after the synced SCL fall following the 8th data bit.

Test Plan:
- Reset, then idle bus (SCL=SDA=1) for 100 clks -> sda_oe=0, busy=0, host_rdata=0 for all host_addr.
- Write [0x78][0x01][0xAA][0x55] then STOP -> ACK on all 4 bytes; reg_wr_valid pulses twice, (1,0xAA) then (2,0x55); regs[1]=0xAA, regs[2]=0x55.
- Write [0x78][0x01], repeated START, [0x79], read 2 bytes ACK then NACK, STOP -> master reads 0xAA, 0x55; sda_oe=0 after NACK; busy falls.
- Address 0xA0 (mismatch) plus 3 bytes -> sda_oe stays 0 throughout; no reg_wr_valid; registers unchanged.
- Pointer 0x0F, write 0x11, 0x22 -> regs[15]=0x11, regs[0]=0x22 (wrap).
- Assert rst during ADDR_ACK with sda_oe=1 -> sda_oe=0 next clk; registers return to 0; the next full transaction works.

Source files
------------

// File: rtl/i2c_slave_regs.sv
// I2C target with a 2^AW-byte register file: pointer write, auto-increment
// burst write/read, host-side write-event stream and combinational read port.
module i2c_slave_regs #(
    parameter logic [6:0]  SLAVE_ADDR = 7'h3c,
    parameter int unsigned AW         = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          scl_i,
    input  logic          sda_i,
    output logic          sda_oe,
    output logic          reg_wr_valid,
    output logic [AW-1:0] reg_wr_addr,
    output logic [7:0]    reg_wr_data,
    input  logic [AW-1:0] host_addr,
    output logic [7:0]    host_rdata,
    output logic          busy
);

    localparam int unsigned DEPTH = 1 << AW;

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
        S_WDATA, S_WDATA_ACK, S_RDATA, S_RDATA_ACK, S_IGNORE
    } state_e;

    state_e        state_q;
    logic          scl_s1_q, scl_s2_q, scl_h_q;
    logic          sda_s1_q, sda_s2_q, sda_h_q;
    logic [7:0]    shift_q;
    logic [7:0]    tx_q;
    logic [2:0]    cnt_q;
    logic          full_q;
    logic          load_q;
    logic          inc_q;
    logic [AW-1:0] ptr_q;
    logic [7:0]    regs_q [DEPTH];
    logic          sda_oe_q, busy_q, wr_valid_q;
    logic [AW-1:0] wr_addr_q;
    logic [7:0]    wr_data_q;

    logic       scl_rise, scl_fall, start_det, stop_det, rx_state;
    logic [7:0] rd_byte;

    assign scl_rise  = scl_s2_q & ~scl_h_q;
    assign scl_fall  = ~scl_s2_q & scl_h_q;
    assign start_det = sda_h_q & ~sda_s2_q & scl_s2_q;
    assign stop_det  = ~sda_h_q & sda_s2_q & scl_s2_q;
    assign rx_state  = (state_q == S_ADDR) || (state_q == S_PTR) ||
                       (state_q == S_WDATA) || (state_q == S_RDATA);
    assign rd_byte   = regs_q[ptr_q];

    assign sda_oe       = sda_oe_q;
    assign busy         = busy_q;
    assign reg_wr_valid = wr_valid_q;
    assign reg_wr_addr  = wr_addr_q;
    assign reg_wr_data  = wr_data_q;
    assign host_rdata   = regs_q[host_addr];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            scl_s1_q   <= 1'b1;
            scl_s2_q   <= 1'b1;
            scl_h_q    <= 1'b1;
            sda_s1_q   <= 1'b1;
            sda_s2_q   <= 1'b1;
            sda_h_q    <= 1'b1;
            shift_q    <= '0;
            tx_q       <= '0;
            cnt_q      <= '0;
            full_q     <= 1'b0;
            load_q     <= 1'b0;
            inc_q      <= 1'b0;
            ptr_q      <= '0;
            sda_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) regs_q[i] <= '0;
        end else begin
            scl_s1_q   <= scl_i;
            scl_s2_q   <= scl_s1_q;
            scl_h_q    <= scl_s2_q;
            sda_s1_q   <= sda_i;
            sda_s2_q   <= sda_s1_q;
            sda_h_q    <= sda_s2_q;
            wr_valid_q <= 1'b0;
            inc_q      <= 1'b0;
            if (inc_q) ptr_q <= ptr_q + AW'(1);

            // Bus conditions override any bit-level activity in the same clk
            if (start_det) begin
                state_q  <= S_ADDR;
                cnt_q    <= '0;
                full_q   <= 1'b0;
                load_q   <= 1'b0;
                sda_oe_q <= 1'b0;
            end else if (stop_det) begin
                state_q  <= S_IDLE;
                full_q   <= 1'b0;
                load_q   <= 1'b0;
                sda_oe_q <= 1'b0;
                busy_q   <= 1'b0;
            end else begin
                if (rx_state && scl_rise) begin
                    shift_q <= {shift_q[6:0], sda_s2_q};
                    cnt_q   <= cnt_q + 3'd1;
                    if (cnt_q == 3'd7) full_q <= 1'b1;
                end
                case (state_q)
                    S_IDLE, S_IGNORE: sda_oe_q <= 1'b0;
                    S_ADDR: if (scl_fall && full_q) begin
                        full_q <= 1'b0;
                        if (shift_q[7:1] == SLAVE_ADDR) begin
                            state_q  <= S_ADDR_ACK;
                            sda_oe_q <= 1'b1;
                            busy_q   <= 1'b1;
                        end else begin
                            state_q  <= S_IGNORE;
                            sda_oe_q <= 1'b0;
                        end
                    end
                    S_ADDR_ACK: if (scl_fall) begin
                        cnt_q  <= '0;
                        full_q <= 1'b0;
                        if (shift_q[0]) begin
                            state_q  <= S_RDATA;
                            tx_q     <= {rd_byte[6:0], 1'b0};
                            sda_oe_q <= ~rd_byte[7];
                        end else begin
                            state_q  <= S_PTR;
                            sda_oe_q <= 1'b0;
                        end
                    end
                    S_PTR: if (scl_fall && full_q) begin
                        full_q   <= 1'b0;
                        ptr_q    <= shift_q[AW-1:0];
                        sda_oe_q <= 1'b1;
                        state_q  <= S_PTR_ACK;
                    end
                    S_PTR_ACK, S_WDATA_ACK: if (scl_fall) begin
                        sda_oe_q <= 1'b0;
                        cnt_q    <= '0;
                        state_q  <= S_WDATA;
                    end
                    S_WDATA: if (scl_fall && full_q) begin
                        full_q        <= 1'b0;
                        regs_q[ptr_q] <= shift_q;
                        wr_valid_q    <= 1'b1;
                        wr_addr_q     <= ptr_q;
                        wr_data_q     <= shift_q;
                        inc_q         <= 1'b1;
                        sda_oe_q      <= 1'b1;
                        state_q       <= S_WDATA_ACK;
                    end
                    // Byte is captured at its first-bit drive so later writes cannot tear it
                    S_RDATA: if (scl_fall) begin
                        if (load_q) begin
                            load_q   <= 1'b0;
                            tx_q     <= {rd_byte[6:0], 1'b0};
                            sda_oe_q <= ~rd_byte[7];
                        end else if (full_q) begin
                            full_q   <= 1'b0;
                            sda_oe_q <= 1'b0;
                            state_q  <= S_RDATA_ACK;
                        end else begin
                            sda_oe_q <= ~tx_q[7];
                            tx_q     <= {tx_q[6:0], 1'b0};
                        end
                    end
                    S_RDATA_ACK: if (scl_rise) begin
                        if (!sda_s2_q) begin
                            ptr_q   <= ptr_q + AW'(1);
                            cnt_q   <= '0;
                            full_q  <= 1'b0;
                            load_q  <= 1'b1;
                            state_q <= S_RDATA;
                        end else begin
                            busy_q   <= 1'b0;
                            sda_oe_q <= 1'b0;
                            state_q  <= S_IGNORE;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave_regs.sv
// Bit-banged I2C master driving i2c_slave_regs, checked against a byte-level
// register-file/pointer model with randomized bursts.
module tb_i2c_slave_regs;

    localparam int unsigned AW    = 4;
    localparam int          DEPTH = 16;
    localparam int          Q     = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          m_scl, m_sda;
    logic          sda_line;
    logic          sda_oe, reg_wr_valid, busy;
    logic [AW-1:0] reg_wr_addr, host_addr;
    logic [7:0]    reg_wr_data, host_rdata;

    logic [7:0]  model_regs [DEPTH];
    int          model_ptr;
    logic [11:0] exp_wr[$];
    logic [11:0] got_wr[$];
    logic [7:0]  wq[$];
    int          n_checks = 0;
    int          n_errors = 0;
    bit          mon_en = 1'b0;
    int          oe_seen = 0;

    assign sda_line = m_sda & ~sda_oe;

    always #5 clk = ~clk;

    i2c_slave_regs #(.SLAVE_ADDR(7'h3c), .AW(AW)) dut (
        .clk(clk), .rst(rst), .scl_i(m_scl), .sda_i(sda_line), .sda_oe(sda_oe),
        .reg_wr_valid(reg_wr_valid), .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data),
        .host_addr(host_addr), .host_rdata(host_rdata), .busy(busy)
    );

    always @(negedge clk) begin
        if (reg_wr_valid) got_wr.push_back({reg_wr_addr, reg_wr_data});
        if (mon_en && sda_oe) oe_seen++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_q(input int n);
        repeat (n * Q) @(negedge clk);
    endtask

    task automatic write_bit(input logic b);
        m_sda = b; wait_q(1); m_scl = 1'b1; wait_q(2); m_scl = 1'b0; wait_q(1);
    endtask

    task automatic read_bit(output logic b);
        m_sda = 1'b1; wait_q(1); m_scl = 1'b1; wait_q(1);
        b = sda_line; wait_q(1); m_scl = 1'b0; wait_q(1);
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; wait_q(1); m_scl = 1'b1; wait_q(1);
        m_sda = 1'b0; wait_q(1); m_scl = 1'b0; wait_q(1);
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; wait_q(1); m_scl = 1'b1; wait_q(1); m_sda = 1'b1; wait_q(1);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) write_bit(b[i]);
        read_bit(r);
        ack = ~r;
    endtask

    task automatic recv_byte(input logic ack, output logic [7:0] b);
        logic [7:0] t;
        logic r;
        for (int i = 7; i >= 0; i--) begin
            read_bit(r);
            t[i] = r;
        end
        write_bit(~ack);
        b = t;
    endtask

    task automatic compare_wr();
        int n;
        wait_q(1);
        check_eq("wr_count", 32'(got_wr.size()), 32'(exp_wr.size()));
        n = (got_wr.size() < exp_wr.size()) ? got_wr.size() : exp_wr.size();
        for (int i = 0; i < n; i++) check_eq("wr_event", 32'(got_wr[i]), 32'(exp_wr[i]));
        got_wr.delete();
        exp_wr.delete();
    endtask

    task automatic check_regs();
        for (int i = 0; i < DEPTH; i++) begin
            host_addr = AW'(i);
            #1;
            check_eq("host_rdata", 32'(host_rdata), 32'(model_regs[i]));
        end
    endtask

    // Writes pointer then every byte in wq; model tracks expected events.
    task automatic write_txn(input logic [7:0] ptr);
        logic ack;
        i2c_start();
        send_byte({7'h3c, 1'b0}, ack);
        check_eq("addr_w_ack", 32'(ack), 32'd1);
        check_eq("busy_after_addr", 32'(busy), 32'd1);
        send_byte(ptr, ack);
        check_eq("ptr_ack", 32'(ack), 32'd1);
        model_ptr = int'(ptr) % DEPTH;
        foreach (wq[i]) begin
            send_byte(wq[i], ack);
            check_eq("data_ack", 32'(ack), 32'd1);
            model_regs[model_ptr] = wq[i];
            exp_wr.push_back({AW'(model_ptr), wq[i]});
            model_ptr = (model_ptr + 1) % DEPTH;
        end
        i2c_stop();
        check_eq("busy_after_stop", 32'(busy), 32'd0);
        compare_wr();
    endtask

    // Sets pointer, repeated START, reads n bytes ACKing all but the last.
    task automatic read_txn(input logic [7:0] ptr, input int n);
        logic ack;
        logic [7:0] b;
        i2c_start();
        send_byte({7'h3c, 1'b0}, ack);
        check_eq("rd_addr_w_ack", 32'(ack), 32'd1);
        send_byte(ptr, ack);
        check_eq("rd_ptr_ack", 32'(ack), 32'd1);
        model_ptr = int'(ptr) % DEPTH;
        i2c_start();
        send_byte({7'h3c, 1'b1}, ack);
        check_eq("addr_r_ack", 32'(ack), 32'd1);
        for (int i = 0; i < n; i++) begin
            recv_byte(i < n - 1, b);
            check_eq("rd_data", 32'(b), 32'(model_regs[model_ptr]));
            if (i < n - 1) model_ptr = (model_ptr + 1) % DEPTH;
        end
        check_eq("oe_after_nack", 32'(sda_oe), 32'd0);
        check_eq("busy_after_nack", 32'(busy), 32'd0);
        i2c_stop();
        compare_wr();
    endtask

    initial begin
        logic ack;
        logic [7:0] a;
        logic [7:0] p;
        int n;
        rst = 1'b1; m_scl = 1'b1; m_sda = 1'b1; host_addr = '0;
        for (int i = 0; i < DEPTH; i++) model_regs[i] = 8'h00;
        model_ptr = 0;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (100) @(negedge clk);
        check_eq("idle_oe", 32'(sda_oe), 32'd0);
        check_eq("idle_busy", 32'(busy), 32'd0);
        check_regs();

        wq.delete(); wq.push_back(8'hAA); wq.push_back(8'h55);
        write_txn(8'h01);
        check_regs();

        read_txn(8'h01, 2);

        // Foreign address: no ACK, no drive, no writes
        i2c_start();
        oe_seen = 0; mon_en = 1'b1;
        send_byte(8'hA0, ack);
        check_eq("mismatch_addr_ack", 32'(ack), 32'd0);
        for (int i = 0; i < 3; i++) begin
            send_byte(8'($urandom_range(0, 255)), ack);
            check_eq("mismatch_data_ack", 32'(ack), 32'd0);
        end
        i2c_stop();
        mon_en = 1'b0;
        check_eq("mismatch_oe_seen", 32'(oe_seen), 32'd0);
        compare_wr();
        check_regs();

        wq.delete(); wq.push_back(8'h11); wq.push_back(8'h22);
        write_txn(8'h0F);
        check_regs();

        // Reset while the address ACK is being driven
        i2c_start();
        a = 8'h78;
        for (int i = 7; i >= 0; i--) write_bit(a[i]);
        check_eq("ack_driven", 32'(sda_oe), 32'd1);
        @(negedge clk) rst = 1'b1;
        @(posedge clk) #1;
        check_eq("oe_after_rst", 32'(sda_oe), 32'd0);
        check_eq("busy_after_rst", 32'(busy), 32'd0);
        @(negedge clk) rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) model_regs[i] = 8'h00;
        model_ptr = 0;
        got_wr.delete(); exp_wr.delete();
        check_regs();
        m_sda = 1'b0; wait_q(1); m_scl = 1'b1; wait_q(1); m_sda = 1'b1; wait_q(1);

        for (int it = 0; it < 6; it++) begin
            p = 8'($urandom_range(0, 255));
            n = int'($urandom_range(1, 4));
            wq.delete();
            for (int i = 0; i < n; i++) wq.push_back(8'($urandom_range(0, 255)));
            write_txn(p);
            read_txn(p, n);
        end
        check_regs();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
